// File: rtl/count3_fsm_pkg.sv
// ============================================================================
// Module      : count3_fsm_pkg
// Description : Shared constants, state encoding and Gray helper for count3_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count3_fsm_pkg;

    localparam int CNT_W = 3;
    localparam int OUT_W = 4;

    typedef enum logic [CNT_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    function automatic logic [CNT_W-1:0] to_gray(input logic [CNT_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/count3_bin2gray.sv
// ============================================================================
// Module      : count3_bin2gray
// Description : Purely combinational 3-bit binary-to-Gray converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count3_bin2gray
    import count3_fsm_pkg::*;
(
    input  logic [CNT_W-1:0] bin_i,
    output logic [CNT_W-1:0] gray_o
);

    assign gray_o = to_gray(bin_i);

endmodule

`default_nettype wire

// File: rtl/count3_fsm.sv
// ============================================================================
// Module      : count3_fsm
// Description : 8-state Moore up-counter with registered wrap pulse on bit [3].
//               Define COUNT3_FSM_GRAY_OUT_EN to emit the count in Gray code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count3_fsm
    import count3_fsm_pkg::*;
(
    output logic [OUT_W-1:0] current_state,
    input  logic             clock,
    input  logic             reset,
    input  logic             count_up
);

    state_t            state_q = S0;
    logic [OUT_W-1:0]  out_q   = '0;

    state_t            state_d;
    logic              wrap_d;
    logic [CNT_W-1:0]  code_d;

    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (count_up) begin
            case (state_q)
                S0:      state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = S3;
                S3:      state_d = S4;
                S4:      state_d = S5;
                S5:      state_d = S6;
                S6:      state_d = S7;
                S7: begin
                    state_d = S0;
                    wrap_d  = 1'b1;
                end
                default: begin
                    state_d = S0;
                    wrap_d  = 1'b0;
                end
            endcase
        end
    end

    // Output code is derived from the next state so it lands in the same flop
    // stage as the state itself; no decode sits after the register.
`ifdef COUNT3_FSM_GRAY_OUT_EN
    count3_bin2gray u_bin2gray (
        .bin_i  (state_d),
        .gray_o (code_d)
    );
`else
    assign code_d = state_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= {wrap_d, code_d};
        end
    end

    assign current_state = out_q;

endmodule

`default_nettype wire

// File: tb/tb_count3_fsm.sv
// ============================================================================
// Module      : tb_count3_fsm
// Description : Scoreboard bench for count3_fsm (binary or Gray build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count3_fsm;

    logic       clock;
    logic       reset;
    logic       count_up;
    logic [3:0] current_state;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];

`ifdef COUNT3_FSM_GRAY_OUT_EN
    localparam logic [2:0] ENC [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                       3'b110, 3'b111, 3'b101, 3'b100};
`else
    localparam logic [2:0] ENC [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                       3'b100, 3'b101, 3'b110, 3'b111};
`endif

    count3_fsm dut (
        .current_state (current_state),
        .clock         (clock),
        .reset         (reset),
        .count_up      (count_up)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ex(input logic flag, input int n);
        return {flag, ENC[n]};
    endfunction

    // Drive one edge's worth of inputs and queue the response expected after it.
    task automatic step(input logic r, input logic u, input logic [3:0] e);
        reset    = r;
        count_up = u;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            chk("edge", current_state, e);
        end
    end

    initial begin
        logic [2:0] prev;
        reset    = 1'b0;
        count_up = 1'b0;
        #1;
        chk("powerup", current_state, 4'b0000);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        count_up = 1'b1;
        chk("pre_edge_after_glitch_reset", current_state, 4'b0000);

        // Count up from power-up; the 8th edge wraps.
        prev = current_state[2:0];
        for (int n = 1; n <= 8; n++) begin
            step(1'b0, 1'b1, ex(n == 8, n % 8));
`ifdef COUNT3_FSM_GRAY_OUT_EN
            chk("gray_one_bit", {3'b000, 1'($countones(current_state[2:0] ^ prev) == 1)}, 4'b0001);
            prev = current_state[2:0];
`endif
        end
        step(1'b0, 1'b1, ex(1'b0, 1));
        step(1'b0, 1'b1, ex(1'b0, 2));
        step(1'b0, 1'b1, ex(1'b0, 3));

        // Hold at 3 for three edges, then resume.
        step(1'b0, 1'b0, ex(1'b0, 3));
        step(1'b0, 1'b0, ex(1'b0, 3));
        step(1'b0, 1'b0, ex(1'b0, 3));
        step(1'b0, 1'b1, ex(1'b0, 4));

        // count_up toggles between edges; only the edge value counts.
        count_up = 1'b0;
        #2 count_up = 1'b1;
        #1 count_up = 1'b0;
        step(1'b0, 1'b1, ex(1'b0, 5));

        // Synchronous reset mid-count wins over count_up.
        step(1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, ex(1'b0, 1));

        // Reset at state 7 must not produce the wrap pulse.
        for (int n = 2; n <= 7; n++) step(1'b0, 1'b1, ex(1'b0, n));
        step(1'b1, 1'b1, 4'b0000);
        step(1'b0, 1'b1, ex(1'b0, 1));

        // Hold on a wrap-candidate state, then wrap for real.
        for (int n = 2; n <= 7; n++) step(1'b0, 1'b1, ex(1'b0, n));
        step(1'b0, 1'b0, ex(1'b0, 7));
        step(1'b0, 1'b1, ex(1'b1, 0));
        step(1'b0, 1'b0, ex(1'b0, 0));

        repeat (2) @(posedge clock);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
